ghash_tag_verify: RTL and testbench
===================================

# ghash_tag_verify

Decrypt-side authentication checker for the AES-GCM datapath. It consumes the receive stream of AAD blocks, ciphertext blocks and the final length block, and accumulates GHASH with a digit-serial GF(2^128) multiplier. It then forms the tag as GHASH ⊕ E_K(J0) and compares it against the received tag. It is the consumer counterpart of the transmit-side GHASH/tag generator and sits between the AES-CTR core and the packet output gate.

## Interface
- DATA_WIDTH, 128, block width; only 128 is supported.
- DIGIT, 8, multiplier bits consumed per cycle; must divide 128. N = 128/DIGIT multiply cycles.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start_i  in  1  begins a new message; honoured only in IDLE.
- h_i  in  128  hash subkey H; sampled when start_i is honoured.
- ek_j0_i  in  128  E_K(J0); sampled when start_i is honoured.
- blk_valid_i  in  1  block available.
- blk_ready_o  out  1  block accepted when blk_valid_i and blk_ready_o are both high on a rising edge.
- blk_data_i  in  128  padded AAD, ciphertext or length block, in GCM bit order (bit 127 = x^0).
- blk_last_i  in  1  marks the length block; qualified by the handshake.
- tag_i  in  128  received tag; sampled on the handshake with blk_last_i=1.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse; tag_o and pass_o are valid in this cycle.
- tag_o  out  128  computed tag; held until the next honoured start_i.
- pass_o  out  1  tag_o == latched tag_i; held with tag_o.

## Operation
- States and transitions:
  - IDLE: start_i latches H and EKJ0, clears X to 0, and moves to WAIT.
  - WAIT: blk_ready_o=1. On handshake, X ← X ⊕ blk_data_i, latch blk_last_i (and tag_i if last), clear the digit counter, and move to MULT.
  - MULT: N cycles. At the end, X ← X·H. Go to WAIT if the latched last=0. If last=1, register tag_o=X·H⊕EKJ0, set pass_o, pulse done_o, and return to IDLE.
- Multiply algorithm (GCM right-shift form): Z=0, V=H. For each bit of the multiplicand, MSB (bit 127) first:
  - if the bit is 1, Z ^= V;
  - V = V[0] ? (V>>1) ^ R : V>>1, with R = 0xE1 followed by 120 zero bits.
- Each MULT cycle processes DIGIT consecutive bits combinationally, unrolled. The multiplicand is shifted left by DIGIT per cycle.
- All arithmetic is XOR-only, 128-bit. No carries and no width growth.
- blk_ready_o is low in IDLE and MULT. Valid data offered while ready is low is not consumed.
- start_i outside IDLE is ignored. A message in progress is never restarted.
- The caller is responsible for the length block (len(A)‖len(C), 64 bits each). The block does no counting.
- A message consisting only of the length block is legal: GHASH = 0·H⊕len.
- Reset mid-operation: state=IDLE and all registers cleared immediately. No done_o is produced for the aborted message.
- Reset values: blk_ready_o=0, busy_o=0, done_o=0, tag_o=0, pass_o=0. Internal X, Z, V, H, EKJ0 and tag registers are 0.

## Timing
- start_i honoured at edge s: WAIT from cycle s+1, with blk_ready_o=1 in that cycle.
- Handshake at edge t: MULT occupies cycles t+1..t+N, and blk_ready_o=0 throughout.
- Non-last block: blk_ready_o=1 again in cycle t+N+1.
- Last block: done_o=1 in cycle t+N+1 only, with tag_o and pass_o valid. busy_o=0 from the same cycle.
- A new start_i is accepted in the done_o cycle (IDLE) at the earliest.
- Throughput is one block per N+1 cycles (17 at DIGIT=8). Latency from the last handshake to done_o is N+1.
- All outputs are registered. There are no combinational input-to-output paths.

## Test plan
- Identity multiply: H=b83b533708bf535d0aa6e52980d53b78, EKJ0=0, single last block 80000000000000000000000000000000 -> tag_o=H; pass_o=1 only if tag_i=H.
- GCM test case 1: H=66e94bd4ef8a2c3b884cfa59ca342b2e, EKJ0=58e2fccefa7e3061367f1d57a4e7455a, single last block 0 -> tag_o=58e2fccefa7e3061367f1d57a4e7455a; with tag_i equal, pass_o=1.
- GCM test case 2: same H and EKJ0, blocks 0388dace60b6a392f328c2b971b2fe78 then last block 00000000000000000000000000000080, tag_i=ab6e47d42cec13bdf53a67b21257bddf:
  - tag_o=ab6e47d42cec13bdf53a67b21257bddf, pass_o=1;
  - done_o exactly 17 cycles after the last handshake (DIGIT=8).
- Tamper: repeat case 2 with ciphertext bit 0 flipped -> tag_o differs from tag_i, pass_o=0; done_o timing unchanged.
- Back-pressure and ignore rules:
  - blk_valid_i held high continuously -> blocks are consumed only in WAIT, one per 17 cycles;
  - start_i pulsed during MULT -> ignored, and the result equals case 2.
- Reset mid-MULT of case 2 -> all outputs 0 immediately and no done_o. Rerunning case 2 afterwards passes.

Source files
------------

// File: rtl/ghash_tag_verify.sv
// Receive-side GCM tag checker: digit-serial GHASH over AAD/ciphertext/length
// blocks, then tag = GHASH ^ E_K(J0) compared against the received tag.
module ghash_tag_verify #(
  parameter int DATA_WIDTH = 128,
  parameter int DIGIT      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] h_i,
  input  logic [DATA_WIDTH-1:0] ek_j0_i,
  input  logic                  blk_valid_i,
  output logic                  blk_ready_o,
  input  logic [DATA_WIDTH-1:0] blk_data_i,
  input  logic                  blk_last_i,
  input  logic [DATA_WIDTH-1:0] tag_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] tag_o,
  output logic                  pass_o
);

  localparam int N  = DATA_WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [DATA_WIDTH-1:0] R_POLY = {8'hE1, {(DATA_WIDTH-8){1'b0}}};

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    WAIT_S = 2'd1,
    MULT_S = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] h_q, h_d;
  logic [DATA_WIDTH-1:0] ek_q, ek_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] z_q, z_d;
  logic [DATA_WIDTH-1:0] v_q, v_d;
  logic [DATA_WIDTH-1:0] rtag_q, rtag_d;
  logic [DATA_WIDTH-1:0] tag_q, tag_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  pass_q, pass_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;

  logic [DATA_WIDTH-1:0] z_step_s;
  logic [DATA_WIDTH-1:0] v_step_s;
  logic [DATA_WIDTH-1:0] tag_calc_s;

  // One multiplier digit: DIGIT multiplicand bits (MSB first) unrolled.
  always_comb begin
    z_step_s = z_q;
    v_step_s = v_q;
    for (int i = 0; i < DIGIT; i++) begin
      if (a_q[DATA_WIDTH-1-i]) begin
        z_step_s = z_step_s ^ v_step_s;
      end else begin
        z_step_s = z_step_s;
      end
      if (v_step_s[0]) begin
        v_step_s = (v_step_s >> 1) ^ R_POLY;
      end else begin
        v_step_s = v_step_s >> 1;
      end
    end
  end

  assign tag_calc_s = z_step_s ^ ek_q;

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    ek_d    = ek_q;
    x_d     = x_q;
    a_d     = a_q;
    z_d     = z_q;
    v_d     = v_q;
    rtag_d  = rtag_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE_S: begin
        if (start_i) begin
          state_d = WAIT_S;
          h_d     = h_i;
          ek_d    = ek_j0_i;
          x_d     = '0;
          rtag_d  = '0;
          tag_d   = '0;
          pass_d  = 1'b0;
        end else begin
          state_d = IDLE_S;
        end
      end
      WAIT_S: begin
        if (blk_valid_i && ready_q) begin
          state_d = MULT_S;
          x_d     = x_q ^ blk_data_i;
          a_d     = x_q ^ blk_data_i;
          z_d     = '0;
          v_d     = h_q;
          cnt_d   = '0;
          last_d  = blk_last_i;
          if (blk_last_i) begin
            rtag_d = tag_i;
          end else begin
            rtag_d = rtag_q;
          end
        end else begin
          state_d = WAIT_S;
        end
      end
      MULT_S: begin
        z_d = z_step_s;
        v_d = v_step_s;
        a_d = a_q << DIGIT;
        if (cnt_q == CNT_LAST) begin
          x_d = z_step_s;
          if (last_q) begin
            state_d = IDLE_S;
            tag_d   = tag_calc_s;
            pass_d  = (tag_calc_s == rtag_q);
            done_d  = 1'b1;
          end else begin
            state_d = WAIT_S;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE_S;
      end
    endcase
    // Handshake and status outputs are registered from the next state.
    ready_d = (state_d == WAIT_S);
    busy_d  = (state_d != IDLE_S);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE_S;
      h_q     <= '0;
      ek_q    <= '0;
      x_q     <= '0;
      a_q     <= '0;
      z_q     <= '0;
      v_q     <= '0;
      rtag_q  <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      ek_q    <= ek_d;
      x_q     <= x_d;
      a_q     <= a_d;
      z_q     <= z_d;
      v_q     <= v_d;
      rtag_q  <= rtag_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign blk_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign tag_o       = tag_q;
  assign pass_o      = pass_q;

endmodule

// File: tb/tb_ghash_tag_verify.sv
// Scoreboard bench for ghash_tag_verify: a polynomial-arithmetic GF(2^128)
// model predicts tag/pass/latency; a negedge monitor checks every done_o.
module tb_ghash_tag_verify;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic [127:0] h_i = '0;
  logic [127:0] ek_j0_i = '0;
  logic         blk_valid_i = 1'b0;
  logic         blk_ready_o;
  logic [127:0] blk_data_i = '0;
  logic         blk_last_i = 1'b0;
  logic [127:0] tag_i = '0;
  logic         busy_o;
  logic         done_o;
  logic [127:0] tag_o;
  logic         pass_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [127:0] tag;
    logic         pass;
    int           cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [127:0] blk_buf[0:7];

  ghash_tag_verify #(.DATA_WIDTH(128), .DIGIT(8)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .h_i(h_i), .ek_j0_i(ek_j0_i),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .blk_data_i(blk_data_i),
    .blk_last_i(blk_last_i), .tag_i(tag_i), .busy_o(busy_o), .done_o(done_o),
    .tag_o(tag_o), .pass_o(pass_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // GF(2^128) product via plain polynomial multiply and reduction
  // modulo x^128 + x^7 + x^2 + x + 1 (bit 127 of a GCM block = x^0).
  function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
    logic [254:0] p;
    logic [127:0] ar, br, r;
    for (int i = 0; i < 128; i++) begin
      ar[i] = a[127-i];
      br[i] = b[127-i];
    end
    p = '0;
    for (int i = 0; i < 128; i++)
      if (ar[i]) p = p ^ ({127'd0, br} << i);
    for (int k = 254; k >= 128; k--) begin
      if (p[k]) begin
        p[k]       = 1'b0;
        p[k - 121] = ~p[k - 121];
        p[k - 126] = ~p[k - 126];
        p[k - 127] = ~p[k - 127];
        p[k - 128] = ~p[k - 128];
      end
    end
    for (int i = 0; i < 128; i++) r[127-i] = p[i];
    return r;
  endfunction

  // Monitor: every done_o pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("tag_o", tag_o, e.tag);
        chk("pass_o", {127'd0, pass_o}, {127'd0, e.pass});
        chk("done_latency", 128'(cyc), 128'(e.cyc));
        chk("busy_at_done", {127'd0, busy_o}, 128'd0);
      end
    end
  end

  // Runs one message of nblk blocks from blk_buf; tag_i is either the model's
  // tag (good), tg, and the expected tag can be pinned to a known constant.
  task automatic run_msg(input logic [127:0] h, input logic [127:0] ek, input int nblk,
                         input logic [127:0] tg, input bit good, input bit poke,
                         input bit has_exp, input logic [127:0] exp_tag);
    logic [127:0] x, etag, rtag;
    int prev_hs, hs, w;
    x = '0;
    for (int i = 0; i < nblk; i++) x = gf_mul(x ^ blk_buf[i], h);
    etag = has_exp ? exp_tag : (x ^ ek);
    rtag = good ? etag : tg;

    @(negedge clk);
    start_i = 1'b1; h_i = h; ek_j0_i = ek;
    @(negedge clk);
    start_i = 1'b0; h_i = {$urandom, $urandom, $urandom, $urandom};
    ek_j0_i = {$urandom, $urandom, $urandom, $urandom};
    chk("busy_after_start", {127'd0, busy_o}, 128'd1);
    chk("ready_after_start", {127'd0, blk_ready_o}, 128'd1);

    prev_hs = -1;
    for (int i = 0; i < nblk; i++) begin
      blk_valid_i = 1'b1;
      blk_data_i  = blk_buf[i];
      blk_last_i  = (i == nblk - 1);
      tag_i       = (i == nblk - 1) ? rtag : {$urandom, $urandom, $urandom, $urandom};
      w = 0;
      while (!blk_ready_o && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!blk_ready_o) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout actual=0 required=1");
        blk_valid_i = 1'b0;
        return;
      end
      hs = cyc + 1;
      if (i == nblk - 1) exp_q.push_back('{tag: etag, pass: (etag == rtag), cyc: hs + N});
      if (prev_hs >= 0) chk("block_spacing", 128'(hs - prev_hs), 128'(N + 1));
      prev_hs = hs;
      @(negedge clk);
      chk("ready_low_in_mult", {127'd0, blk_ready_o}, 128'd0);
      if (poke) begin
        start_i = 1'b1; h_i = ~h; ek_j0_i = ~ek;
        @(negedge clk);
        start_i = 1'b0;
      end
    end
    blk_valid_i = 1'b0;
    blk_last_i  = 1'b0;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=none required=done_o");
      exp_q.delete();
    end
  endtask

  localparam logic [127:0] H_ID  = 128'hb83b533708bf535d0aa6e52980d53b78;
  localparam logic [127:0] H_TC  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] EK_TC = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] CT2   = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] LEN2  = 128'h00000000000000000000000000000080;
  localparam logic [127:0] TAG2  = 128'hab6e47d42cec13bdf53a67b21257bddf;

  initial begin
    int nb;
    logic [127:0] rh, rek;
    repeat (3) @(negedge clk);
    chk("rst_ready", {127'd0, blk_ready_o}, 128'd0);
    chk("rst_busy", {127'd0, busy_o}, 128'd0);
    chk("rst_done", {127'd0, done_o}, 128'd0);
    chk("rst_tag", tag_o, 128'd0);
    chk("rst_pass", {127'd0, pass_o}, 128'd0);
    rst = 1'b0;

    // Identity multiply, matching and non-matching received tag.
    blk_buf[0] = 128'h80000000000000000000000000000000;
    run_msg(H_ID, 128'd0, 1, H_ID, 1'b0, 1'b0, 1'b1, H_ID);
    run_msg(H_ID, 128'd0, 1, ~H_ID, 1'b0, 1'b0, 1'b1, H_ID);
    // GCM test case 1.
    blk_buf[0] = 128'd0;
    run_msg(H_TC, EK_TC, 1, EK_TC, 1'b0, 1'b0, 1'b1, EK_TC);
    // GCM test case 2, then with start_i poked during MULT.
    blk_buf[0] = CT2; blk_buf[1] = LEN2;
    run_msg(H_TC, EK_TC, 2, TAG2, 1'b0, 1'b0, 1'b1, TAG2);
    run_msg(H_TC, EK_TC, 2, TAG2, 1'b0, 1'b1, 1'b1, TAG2);
    // Tamper: ciphertext bit 0 flipped.
    blk_buf[0] = CT2 ^ 128'd1;
    run_msg(H_TC, EK_TC, 2, TAG2, 1'b0, 1'b0, 1'b0, 128'd0);

    // Reset in the middle of MULT of case 2.
    blk_buf[0] = CT2;
    @(negedge clk);
    start_i = 1'b1; h_i = H_TC; ek_j0_i = EK_TC;
    @(negedge clk);
    start_i = 1'b0; blk_valid_i = 1'b1; blk_data_i = LEN2; blk_last_i = 1'b1; tag_i = TAG2;
    @(negedge clk);
    blk_valid_i = 1'b0; blk_last_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {127'd0, blk_ready_o}, 128'd0);
    chk("mid_rst_busy", {127'd0, busy_o}, 128'd0);
    chk("mid_rst_done", {127'd0, done_o}, 128'd0);
    chk("mid_rst_tag", tag_o, 128'd0);
    chk("mid_rst_pass", {127'd0, pass_o}, 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    blk_buf[0] = CT2; blk_buf[1] = LEN2;
    run_msg(H_TC, EK_TC, 2, TAG2, 1'b0, 1'b0, 1'b1, TAG2);

    // Randomized messages against the model.
    for (int m = 0; m < 10; m++) begin
      nb = $urandom_range(1, 5);
      for (int i = 0; i < nb; i++) blk_buf[i] = {$urandom, $urandom, $urandom, $urandom};
      rh  = {$urandom, $urandom, $urandom, $urandom};
      rek = {$urandom, $urandom, $urandom, $urandom};
      run_msg(rh, rek, nb, {$urandom, $urandom, $urandom, $urandom},
              ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0), 1'b0, 128'd0);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
